mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Memory arbiter sitting directly downstream of the instruction cache and the data cache. Merges their fill/writeback requests onto the single RAM port.
- Grants one requester at a time through a registered FSM.
- Holds the granted address and data stable for the whole access.
- Returns completion through per-cache wait signals.
- Data-side requests have priority; the optional starvation guard bounds instruction-side latency.

Parameters:
MAX_DSTREAK, 4, consecutive data grants allowed while iREN is pending before an instruction grant is forced (starvation guard only); valid range 1..15
CNT_W, 4, width of the streak counter; must satisfy MAX_DSTREAK < 2**CNT_W

Ports:
clk  in  1  clock
n_rst  in  1  reset, asynchronous, active-low
iREN  in  1  icache fill request
iaddr  in  32  icache word address
iwait  out  1  0 = iload valid this cycle, access complete
iload  out  32  instruction word to icache
dREN  in  1  dcache read request
dWEN  in  1  dcache write request
daddr  in  32  dcache word address
dstore  in  32  dcache write data
dwait  out  1  0 = dcache access complete this cycle
dload  out  32  data word to dcache
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramaddr  out  32  RAM address
ramstore  out  32  RAM write data
ramload  in  32  RAM read data
ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR

Behaviour:
- States: IDLE, IFETCH, DREAD, DWRITE; state register reset to IDLE.
- Reset values: ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iwait=1, dwait=1, streak counter=0.
- IDLE transitions, evaluated in priority order:
  - dWEN -> DWRITE (dWEN wins over dREN when both are high).
  - else dREN -> DREAD.
  - else iREN -> IFETCH.
  - else stay in IDLE.
- On entering a grant state, latch the address, plus dstore for DWRITE, into registers.
- ramaddr and ramstore drive from those registers only, and are stable for the whole access.
- Enable outputs:
  - ramREN=1 in IFETCH and DREAD.
  - ramWEN=1 in DWRITE.
  - Both 0 in IDLE.
- Completion:
  - In a grant state with ramstate==ACCESS, drive the owner's wait=0 combinationally that cycle and return to IDLE on the next edge.
  - iload and dload are combinational pass-throughs of ramload.
- Waits: the wait signal of the non-granted cache is always 1.
- Minimum latency: request seen in IDLE at cycle 0; RAM enable asserted in cycle 1; wait=0 in cycle 1 at the earliest (ACCESS same cycle). The next grant can start no sooner than cycle 3.
- BUSY or FREE while granted: hold state and all outputs.
- ERROR while granted: hold state and keep the enable asserted, so the access is retried; wait stays 1.
- Requester withdrawal:
  - If the owner's request drops while granted and not yet complete, return to IDLE next edge with wait held at 1.
  - For DWRITE, withdrawal means dWEN=0.
- Re-request: back-to-back requests from the same cache are allowed. IDLE always costs one cycle between grants.
- Reset asserted mid-access: immediate return to IDLE and enables to 0, regardless of ramstate.

Optional Feature:
- Macro: ARB_STARVE_GUARD_EN.
- With the macro defined:
  - The streak counter increments on each data grant taken while iREN=1.
  - It clears on any IFETCH grant, or when iREN=0 in IDLE.
  - When counter==MAX_DSTREAK and iREN=1 in IDLE, grant IFETCH even if dREN or dWEN is high.
- Without the macro: strict data priority. The counter and its logic are absent.

Decomposition:
- cpu_types_pkg supplies word_t (32 bits) and ramstate_t (FREE, BUSY, ACCESS, ERROR).
- Add arb_state_t (IDLE, IFETCH, DREAD, DWRITE) to cpu_types_pkg so the cache and system benches can probe the grant state.
- Sub-module: mem_arb_streak, the streak counter with saturate/clear/force-grant output. Instantiate it only under ARB_STARVE_GUARD_EN; everything else is a single module.

Test Plan:
- Icache miss: iREN=1, iaddr=0x0000_0040, ramstate ACCESS on first granted cycle, ramload=0x2402_0005 -> ramREN=1 with ramaddr=0x40 in cycle 1; iwait=0 and iload=0x2402_0005 in cycle 1; IDLE in cycle 2.
- Collision: iREN=1 and dREN=1 at cycle 0, daddr=0x100, iaddr=0x40 -> DREAD granted first (ramaddr=0x100); IFETCH granted after dwait=0 and one IDLE cycle; iwait=1 throughout the DREAD.
- Write wins: dREN=1, dWEN=1, daddr=0x200, dstore=0xDEAD_BEEF, ramstate BUSY 3 cycles then ACCESS -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF stable over 4 cycles; dwait=0 only on the ACCESS cycle.
- ERROR and withdrawal:
  - ramstate=ERROR for 2 cycles in IFETCH -> ramREN stays 1, iwait stays 1.
  - Then drop iREN -> IDLE next edge, ramREN=0, no iwait=0 pulse.
- Reset mid-DWRITE: n_rst low asynchronously in the 2nd BUSY cycle -> ramWEN=0, dwait=1, state IDLE immediately, without waiting for a clock edge.
- ARB_STARVE_GUARD_EN with MAX_DSTREAK=4: iREN held high, dREN re-asserted continuously -> exactly 4 DREAD grants, then one IFETCH, counter back to 0. Without the macro the same stimulus never grants IFETCH.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, RAM handshake state and the memory
// arbiter grant state (visible so cache/system benches can probe it).
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFETCH = 2'd1,
    DREAD  = 2'd2,
    DWRITE = 2'd3
  } arb_state_t;

  // True while the cache that owns the given grant state still requests it.
  function automatic logic owner_requesting(arb_state_t st, logic iren,
                                            logic dren, logic dwen);
    logic req;
    req = 1'b0;
    case (st)
      IFETCH:  req = iren;
      DREAD:   req = dren;
      DWRITE:  req = dwen;
      default: req = 1'b0;
    endcase
    return req;
  endfunction

endpackage

// File: rtl/mem_arb_streak.sv
// Starvation guard for mem_arbiter: counts consecutive data grants taken
// while the icache is waiting and forces an instruction grant at the limit.
// Only instantiated when ARB_STARVE_GUARD_EN is defined.
module mem_arb_streak #(
  parameter int MAX_DSTREAK = 4,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic n_rst,
  input  logic idle,
  input  logic iren,
  input  logic dreq,
  output logic force_ifetch
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_DSTREAK);

  logic [CNT_W-1:0] cnt_reg;

  // Only meaningful in IDLE; the arbiter ignores it in grant states.
  assign force_ifetch = iren && (cnt_reg == LIMIT);

  // Grant decisions happen in IDLE only: an instruction grant (forced, or no
  // data request) or an absent iREN clears the streak, a data grant with
  // iREN pending extends it.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_reg <= '0;
    end else if (idle) begin
      if (!iren || force_ifetch || !dreq) begin
        cnt_reg <= '0;
      end else if (cnt_reg != LIMIT) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Memory arbiter between icache and dcache onto the single RAM port.
// One grant at a time, data side first; address/store data are latched at
// grant so the RAM sees them stable for the whole access. Completion is the
// owner's wait dropping combinationally on the ramstate==ACCESS cycle.
// Optional: define ARB_STARVE_GUARD_EN to bound icache latency with the
// data-grant streak counter (mem_arb_streak).
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int MAX_DSTREAK = 4,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  ramstate_t   ramstate
);

  arb_state_t state_reg;
  word_t      addr_reg;
  word_t      store_reg;
  logic       force_ifetch;
  logic       access_done;

  if (MAX_DSTREAK < 1 || MAX_DSTREAK > 15 || MAX_DSTREAK >= (1 << CNT_W)) begin : g_bad_cfg
    $error("mem_arbiter: MAX_DSTREAK must be 1..15 and below 2**CNT_W");
  end

`ifdef ARB_STARVE_GUARD_EN
  mem_arb_streak #(
    .MAX_DSTREAK(MAX_DSTREAK),
    .CNT_W      (CNT_W)
  ) u_streak (
    .clk         (clk),
    .n_rst       (n_rst),
    .idle        (state_reg == IDLE),
    .iren        (iREN),
    .dreq        (dREN | dWEN),
    .force_ifetch(force_ifetch)
  );
`else
  assign force_ifetch = 1'b0;
`endif

  assign access_done = (ramstate == ACCESS);

  // Grant FSM with registered enables and latched address/store data.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg <= IDLE;
      ramREN    <= 1'b0;
      ramWEN    <= 1'b0;
      addr_reg  <= '0;
      store_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (force_ifetch) begin
            state_reg <= IFETCH;
            ramREN    <= 1'b1;
            addr_reg  <= iaddr;
          end else if (dWEN) begin
            state_reg <= DWRITE;
            ramWEN    <= 1'b1;
            addr_reg  <= daddr;
            store_reg <= dstore;
          end else if (dREN) begin
            state_reg <= DREAD;
            ramREN    <= 1'b1;
            addr_reg  <= daddr;
          end else if (iREN) begin
            state_reg <= IFETCH;
            ramREN    <= 1'b1;
            addr_reg  <= iaddr;
          end
        end
        default: begin
          // Completion wins over withdrawal; BUSY/FREE/ERROR otherwise hold,
          // so an ERROR access is simply retried with the enable kept high.
          if (access_done || !owner_requesting(state_reg, iREN, dREN, dWEN)) begin
            state_reg <= IDLE;
            ramREN    <= 1'b0;
            ramWEN    <= 1'b0;
          end
        end
      endcase
    end
  end

  assign ramaddr  = addr_reg;
  assign ramstore = store_reg;
  assign iload    = ramload;
  assign dload    = ramload;
  assign iwait    = !((state_reg == IFETCH) && access_done);
  assign dwait    = !(((state_reg == DREAD) || (state_reg == DWRITE)) && access_done);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// run against a transaction-level ownership model of the arbiter.
`timescale 1ns/1ps
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int MAXS = 4;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic        iwait, dwait, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore;
  ramstate_t   ramstate;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_DSTREAK(MAXS), .CNT_W(4)) dut (
    .clk(clk), .n_rst(n_rst),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    iREN = 0; dREN = 0; dWEN = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
    ramstate = FREE;
  endtask

  task automatic do_reset();
    idle_inputs();
    n_rst = 0;
    #3;
    @(negedge clk);
    n_rst = 1;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    n_rst = 0;
    #12;
    n_cmp++; if (ramREN !== 1'b0) begin n_bad++; $display("FAIL reset_ren: got %b want 0", ramREN); end
    n_cmp++; if (ramWEN !== 1'b0) begin n_bad++; $display("FAIL reset_wen: got %b want 0", ramWEN); end
    n_cmp++; if (ramaddr !== 32'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", ramaddr); end
    n_cmp++; if (ramstore !== 32'h0) begin n_bad++; $display("FAIL reset_store: got %h want 0", ramstore); end
    n_cmp++; if (iwait !== 1'b1) begin n_bad++; $display("FAIL reset_iwait: got %b want 1", iwait); end
    n_cmp++; if (dwait !== 1'b1) begin n_bad++; $display("FAIL reset_dwait: got %b want 1", dwait); end
    n_cmp++; if (dut.state_reg !== IDLE) begin n_bad++; $display("FAIL reset_state: got %0d want %0d", dut.state_reg, IDLE); end
    @(negedge clk);
    n_rst = 1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_icache_miss();
    tick(); iREN = 1; iaddr = 32'h40; settle();
    n_cmp++; if (ramREN !== 1'b0) begin n_bad++; $display("FAIL imiss_c0_ren: got %b want 0", ramREN); end
    tick(); ramstate = ACCESS; ramload = 32'h2402_0005; settle();
    n_cmp++; if (ramREN !== 1'b1) begin n_bad++; $display("FAIL imiss_ren: got %b want 1", ramREN); end
    n_cmp++; if (ramaddr !== 32'h40) begin n_bad++; $display("FAIL imiss_addr: got %h want 40", ramaddr); end
    n_cmp++; if (iwait !== 1'b0) begin n_bad++; $display("FAIL imiss_iwait: got %b want 0", iwait); end
    n_cmp++; if (iload !== 32'h2402_0005) begin n_bad++; $display("FAIL imiss_iload: got %h want 24020005", iload); end
    n_cmp++; if (dwait !== 1'b1) begin n_bad++; $display("FAIL imiss_dwait: got %b want 1", dwait); end
    tick(); iREN = 0; ramstate = FREE; settle();
    n_cmp++; if (dut.state_reg !== IDLE) begin n_bad++; $display("FAIL imiss_idle: got %0d want %0d", dut.state_reg, IDLE); end
    n_cmp++; if (ramREN !== 1'b0) begin n_bad++; $display("FAIL imiss_ren_off: got %b want 0", ramREN); end
    $display("test_icache_miss done");
  endtask

  task automatic test_collision();
    tick(); iREN = 1; dREN = 1; iaddr = 32'h40; daddr = 32'h100; settle();
    tick(); ramstate = BUSY; settle();
    n_cmp++; if (dut.state_reg !== DREAD) begin n_bad++; $display("FAIL coll_state: got %0d want %0d", dut.state_reg, DREAD); end
    n_cmp++; if (ramaddr !== 32'h100) begin n_bad++; $display("FAIL coll_addr: got %h want 100", ramaddr); end
    n_cmp++; if (iwait !== 1'b1) begin n_bad++; $display("FAIL coll_iwait_busy: got %b want 1", iwait); end
    tick(); ramstate = ACCESS; settle();
    n_cmp++; if (dwait !== 1'b0) begin n_bad++; $display("FAIL coll_dwait: got %b want 0", dwait); end
    n_cmp++; if (iwait !== 1'b1) begin n_bad++; $display("FAIL coll_iwait_acc: got %b want 1", iwait); end
    tick(); dREN = 0; ramstate = FREE; settle();
    n_cmp++; if (dut.state_reg !== IDLE) begin n_bad++; $display("FAIL coll_gap: got %0d want %0d", dut.state_reg, IDLE); end
    tick(); ramstate = ACCESS; settle();
    n_cmp++; if (dut.state_reg !== IFETCH) begin n_bad++; $display("FAIL coll_ifetch: got %0d want %0d", dut.state_reg, IFETCH); end
    n_cmp++; if (ramaddr !== 32'h40) begin n_bad++; $display("FAIL coll_iaddr: got %h want 40", ramaddr); end
    n_cmp++; if (iwait !== 1'b0) begin n_bad++; $display("FAIL coll_iwait_done: got %b want 0", iwait); end
    tick(); idle_inputs(); settle();
    $display("test_collision done");
  endtask

  task automatic test_write_wins();
    tick(); dREN = 1; dWEN = 1; daddr = 32'h200; dstore = 32'hDEAD_BEEF; settle();
    for (int k = 0; k < 4; k++) begin
      tick();
      ramstate = (k < 3) ? BUSY : ACCESS;
      daddr = $urandom; dstore = $urandom;
      settle();
      n_cmp++; if (ramWEN !== 1'b1) begin n_bad++; $display("FAIL wr_wen[%0d]: got %b want 1", k, ramWEN); end
      n_cmp++; if (ramREN !== 1'b0) begin n_bad++; $display("FAIL wr_ren[%0d]: got %b want 0", k, ramREN); end
      n_cmp++; if (ramstore !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL wr_store[%0d]: got %h want deadbeef", k, ramstore); end
      n_cmp++; if (ramaddr !== 32'h200) begin n_bad++; $display("FAIL wr_addr[%0d]: got %h want 200", k, ramaddr); end
      n_cmp++; if (dwait !== (k < 3)) begin n_bad++; $display("FAIL wr_dwait[%0d]: got %b want %0d", k, dwait, (k < 3)); end
    end
    tick(); idle_inputs(); settle();
    n_cmp++; if (ramWEN !== 1'b0) begin n_bad++; $display("FAIL wr_wen_off: got %b want 0", ramWEN); end
    $display("test_write_wins done");
  endtask

  task automatic test_error_withdraw();
    tick(); iREN = 1; iaddr = 32'h80; settle();
    for (int k = 0; k < 2; k++) begin
      tick(); ramstate = ERROR; settle();
      n_cmp++; if (ramREN !== 1'b1) begin n_bad++; $display("FAIL err_ren[%0d]: got %b want 1", k, ramREN); end
      n_cmp++; if (iwait !== 1'b1) begin n_bad++; $display("FAIL err_iwait[%0d]: got %b want 1", k, iwait); end
    end
    tick(); iREN = 0; settle();
    n_cmp++; if (iwait !== 1'b1) begin n_bad++; $display("FAIL wd_iwait: got %b want 1", iwait); end
    tick(); ramstate = FREE; settle();
    n_cmp++; if (dut.state_reg !== IDLE) begin n_bad++; $display("FAIL wd_state: got %0d want %0d", dut.state_reg, IDLE); end
    n_cmp++; if (ramREN !== 1'b0) begin n_bad++; $display("FAIL wd_ren: got %b want 0", ramREN); end
    n_cmp++; if (iwait !== 1'b1) begin n_bad++; $display("FAIL wd_iwait_idle: got %b want 1", iwait); end
    $display("test_error_withdraw done");
  endtask

  task automatic test_reset_mid_write();
    tick(); dWEN = 1; daddr = 32'h300; dstore = 32'hCAFE_0001; settle();
    tick(); ramstate = BUSY; settle();
    n_cmp++; if (ramWEN !== 1'b1) begin n_bad++; $display("FAIL rmw_wen_pre: got %b want 1", ramWEN); end
    tick(); ramstate = BUSY; settle();
    n_rst = 0;
    #1;
    n_cmp++; if (ramWEN !== 1'b0) begin n_bad++; $display("FAIL rmw_wen: got %b want 0", ramWEN); end
    n_cmp++; if (dwait !== 1'b1) begin n_bad++; $display("FAIL rmw_dwait: got %b want 1", dwait); end
    n_cmp++; if (dut.state_reg !== IDLE) begin n_bad++; $display("FAIL rmw_state: got %0d want %0d", dut.state_reg, IDLE); end
    n_cmp++; if (ramaddr !== 32'h0) begin n_bad++; $display("FAIL rmw_addr: got %h want 0", ramaddr); end
    idle_inputs();
    @(negedge clk);
    n_rst = 1;
    tick();
    $display("test_reset_mid_write done");
  endtask

  task automatic test_starvation();
    arb_state_t grants[$];
    int first_if;
    int n_if;
    tick(); iREN = 1; dREN = 1; iaddr = 32'h44; daddr = 32'h144; ramstate = ACCESS; settle();
    for (int c = 0; c < 40; c++) begin
      tick(); settle();
      if (dut.state_reg != IDLE) grants.push_back(dut.state_reg);
`ifdef ARB_STARVE_GUARD_EN
      if (dut.state_reg == IFETCH) begin
        n_cmp++; if (dut.u_streak.cnt_reg !== 4'd0) begin n_bad++; $display("FAIL starve_cnt_clear: got %0d want 0", dut.u_streak.cnt_reg); end
      end
`endif
    end
    first_if = -1;
    n_if = 0;
    foreach (grants[i]) begin
      if (grants[i] == IFETCH) begin
        n_if++;
        if (first_if < 0) first_if = i;
      end
    end
`ifdef ARB_STARVE_GUARD_EN
    n_cmp++; if (first_if !== MAXS) begin n_bad++; $display("FAIL starve_first_if: got %0d want %0d", first_if, MAXS); end
    n_cmp++; if (n_if !== grants.size() / (MAXS + 1)) begin n_bad++; $display("FAIL starve_if_count: got %0d want %0d", n_if, grants.size() / (MAXS + 1)); end
`else
    n_cmp++; if (n_if !== 0) begin n_bad++; $display("FAIL starve_no_if: got %0d want 0", n_if); end
`endif
    n_cmp++; if (grants.size() !== 20) begin n_bad++; $display("FAIL starve_grant_rate: got %0d want 20", grants.size()); end
    tick(); idle_inputs(); tick();
    $display("test_starvation done: %0d grants, %0d ifetch", grants.size(), n_if);
  endtask

  task automatic test_random();
    int          m_own;    // 0 none, 1 icache, 2 dcache read, 3 dcache write
    logic [31:0] m_addr, m_store;
    int          m_streak;
    logic        still, acc, force_i;
    logic [131:0] exp_v, got_v;
    int          errs;
    do_reset();
    m_own = 0; m_addr = 0; m_store = 0; m_streak = 0; errs = 0;
    for (int c = 0; c < 600; c++) begin
      tick();
      iREN = ($urandom_range(0, 3) != 0);
      dREN = $urandom_range(0, 1);
      dWEN = ($urandom_range(0, 3) == 0);
      iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
      ramstate = ramstate_t'($urandom_range(0, 3));
      settle();
      acc = (ramstate == ACCESS);
      exp_v = {(m_own == 1 || m_own == 2), (m_own == 3), !(m_own == 1 && acc),
               !(m_own >= 2 && acc), m_addr, m_store, ramload, ramload};
      got_v = {ramREN, ramWEN, iwait, dwait, ramaddr, ramstore, iload, dload};
      n_cmp++;
      if (got_v !== exp_v) begin
        n_bad++; errs++;
        if (errs <= 8) $display("FAIL rand_cycle%0d: got %h want %h", c, got_v, exp_v);
      end
      // Advance the ownership model to what the next edge should produce.
      if (m_own == 0) begin
        force_i = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
        if (!iREN) m_streak = 0;
        force_i = iREN && (m_streak == MAXS);
`endif
        if (force_i) begin m_own = 1; m_addr = iaddr; end
        else if (dWEN) begin m_own = 3; m_addr = daddr; m_store = dstore; end
        else if (dREN) begin m_own = 2; m_addr = daddr; end
        else if (iREN) begin m_own = 1; m_addr = iaddr; end
        if (m_own == 1) m_streak = 0;
        else if (m_own >= 2 && iREN) m_streak++;
      end else begin
        still = (m_own == 1) ? iREN : (m_own == 2) ? dREN : dWEN;
        if (acc || !still) m_own = 0;
      end
    end
    tick(); idle_inputs(); tick();
    $display("test_random done: 600 cycles, %0d bad", errs);
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_icache_miss();
    test_collision();
    test_write_wins();
    test_error_withdraw();
    test_reset_mid_write();
    test_starvation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: run exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
